mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single CPU memory port between instruction fetch (I-port) and load/store (D-port: LDL/LDH/STL/STH) with round-robin arbitration, one outstanding transaction, and a response watchdog. Sits between the core pipeline and the memory model/controller. All outputs are registered.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- TIMEOUT, 64, max cycles waiting for mem_ack before abort (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  DATA_W  fetched word, valid with i_ack
- i_err  out  1  timeout flag, valid with i_ack
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables (STL low half, STH high half)
- d_ack, d_rdata, d_err  out  1/DATA_W/1  as I-port
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we, mem_addr, mem_wdata, mem_be  out  —  latched request fields
- mem_ack  in  1  completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- busy  out  1  high in BUSY and RESP

## Operation
- Reset: state IDLE, last_grant = D (so I wins first tie), all outputs 0, timeout counter 0.
- IDLE: sample i_req/d_req. One requester → grant it. Both → grant the one not granted last. Latch addr/we/wdata/be (I-port forces we=0, be=all ones), set mem_req=1 next cycle, go BUSY, update last_grant.
- BUSY: hold mem_* stable; counter increments each cycle. mem_ack=1 → next cycle mem_req=0, grantee ack=1, rdata=mem_rdata (stores: rdata=0), err=0, go RESP. Counter reaches TIMEOUT with no mem_ack → mem_req=0, ack=1, err=1, rdata=0, go RESP.
- RESP: one cycle; ack pulse visible; requests ignored; go IDLE, ack/err cleared. Requester must drop req or present new fields by end of RESP cycle.
- mem_ack outside BUSY is ignored (late response after timeout is dropped).
- mem_req is never asserted in IDLE or RESP; at most one of i_ack/d_ack is high.
- Reset mid-transaction: all outputs clear immediately (async), transaction abandoned, no ack issued.

## Timing
- Cycle 0: req sampled in IDLE. Cycle 1: mem_req=1. Memory acks in cycle k≥1 → cycle k+1 ack pulse (RESP), mem_req=0. Cycle k+2: IDLE, new request sampled → mem_req again at k+3.
- Minimum turnaround: 3 cycles per transaction with zero-wait memory (ack in cycle 1).
- Timeout: mem_req high exactly TIMEOUT cycles, error ack in the following cycle.
- Simultaneous mem_ack and counter = TIMEOUT: mem_ack wins, err=0.
- Back-to-back from both ports strictly alternates I, D, I, D.

## Test plan
- Single fetch: i_req, i_addr=0x100, memory acks 2 cycles after mem_req with 0xDEADBEEF → mem_addr=0x100, mem_we=0, i_ack one cycle with i_rdata=0xDEADBEEF, i_err=0, d_ack never.
- Store STH: d_we=1, d_addr=0x40, d_wdata=0x12340000, d_be=4'b1100 → mem_we=1, mem_be=4'b1100, fields stable until mem_ack, d_ack pulse, d_rdata=0.
- Contention: i_req and d_req held continuously from reset, zero-wait memory, 6 transactions → grant order I,D,I,D,I,D; mem_req rises every 3 cycles.
- Timeout: TIMEOUT=8, memory never acks d_req → mem_req high 8 cycles, then d_ack=1, d_err=1, d_rdata=0; mem_ack injected 2 cycles later ignored, busy=0.
- Ack at timeout edge: mem_ack in the 8th BUSY cycle with 0x55AA55AA → err=0, rdata=0x55AA55AA.
- Reset mid-op: assert rst_n=0 while BUSY → mem_req, busy, acks 0 immediately; after release, first tie goes to I-port.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a single outstanding transaction and a response watchdog.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t             state, state_n;
    logic               last_d, last_d_n;
    logic               gnt_d, gnt_d_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic               mem_req_n, mem_we_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [DATA_W-1:0]  mem_wdata_n;
    logic [BE_W-1:0]    mem_be_n;
    logic               i_ack_n, i_err_n, d_ack_n, d_err_n, busy_n;
    logic [DATA_W-1:0]  i_rdata_n, d_rdata_n;

    logic               any_req_c, pick_d_c, expired_c;

    // D wins only when I is idle or I was the previous grantee
    assign any_req_c = i_req | d_req;
    assign pick_d_c  = d_req & (~i_req | ~last_d);
    assign expired_c = (cnt == CNT_W'(TIMEOUT));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last_d    <= 1'b1;
            gnt_d     <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            last_d    <= last_d_n;
            gnt_d     <= gnt_d_n;
            cnt       <= cnt_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_be    <= mem_be_n;
            i_ack     <= i_ack_n;
            i_rdata   <= i_rdata_n;
            i_err     <= i_err_n;
            d_ack     <= d_ack_n;
            d_rdata   <= d_rdata_n;
            d_err     <= d_err_n;
            busy      <= busy_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (any_req_c) state_n = S_BUSY;
            S_BUSY:  if (mem_ack || expired_c) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        last_d_n    = last_d;
        gnt_d_n     = gnt_d;
        cnt_n       = cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_be_n    = mem_be;
        i_ack_n     = 1'b0;
        i_rdata_n   = '0;
        i_err_n     = 1'b0;
        d_ack_n     = 1'b0;
        d_rdata_n   = '0;
        d_err_n     = 1'b0;
        busy_n      = (state_n != S_IDLE);

        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (any_req_c) begin
                    mem_req_n = 1'b1;
                    gnt_d_n   = pick_d_c;
                    last_d_n  = pick_d_c;
                    cnt_n     = CNT_W'(1);
                    if (pick_d_c) begin
                        mem_we_n    = d_we;
                        mem_addr_n  = d_addr;
                        mem_wdata_n = d_wdata;
                        mem_be_n    = d_be;
                    end else begin
                        mem_we_n    = 1'b0;
                        mem_addr_n  = i_addr;
                        mem_wdata_n = '0;
                        mem_be_n    = '1;
                    end
                end
            end
            S_BUSY: begin
                // A response landing on the timeout cycle still counts as success
                if (mem_ack || expired_c) begin
                    mem_req_n = 1'b0;
                    cnt_n     = '0;
                    if (gnt_d) begin
                        d_ack_n   = 1'b1;
                        d_err_n   = ~mem_ack;
                        d_rdata_n = (mem_ack && !mem_we) ? mem_rdata : '0;
                    end else begin
                        i_ack_n   = 1'b1;
                        i_err_n   = ~mem_ack;
                        i_rdata_n = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                mem_req_n = 1'b0;
                cnt_n     = '0;
            end
            default: begin
                mem_req_n = 1'b0;
                cnt_n     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_be = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    bit last_i = 1'b0;   // model: port granted most recently (0 = D)

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_iack"}, 64'(i_ack), 64'd0);
        chk({tag, "_dack"}, 64'(d_ack), 64'd0);
        chk({tag, "_memreq"}, 64'(mem_req), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Runs one transaction from IDLE; memory acks in BUSY cycle lat (lat > TO: never).
    // Returns in the RESP cycle with the model's grant decision.
    task automatic run_txn(input string tag, input int lat, input logic [DW-1:0] rd,
                           output bit g_i);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rdata;
        bit            tmo;
        g_i     = i_req && (!d_req || !last_i);
        e_addr  = g_i ? i_addr : d_addr;
        e_we    = g_i ? 1'b0 : d_we;
        e_be    = g_i ? '1 : d_be;
        e_wdata = d_wdata;
        last_i  = g_i;
        tmo     = (lat > int'(TO));
        e_rdata = (tmo || e_we) ? '0 : rd;
        tick();
        rise_cyc = cyc;
        for (int c = 1; c <= int'(TO); c++) begin
            chk({tag, "_memreq"}, 64'(mem_req), 64'd1);
            chk({tag, "_addr"}, 64'(mem_addr), 64'(e_addr));
            chk({tag, "_we"}, 64'(mem_we), 64'(e_we));
            chk({tag, "_be"}, 64'(mem_be), 64'(e_be));
            if (!g_i) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e_wdata));
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_noack"}, 64'({i_ack, d_ack}), 64'd0);
            if (c == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick();
            mem_ack = 1'b0;
            if (c == lat) break;
        end
        chk({tag, "_resp_memreq"}, 64'(mem_req), 64'd0);
        chk({tag, "_resp_busy"}, 64'(busy), 64'd1);
        chk({tag, "_iack"}, 64'(i_ack), 64'(g_i));
        chk({tag, "_dack"}, 64'(d_ack), 64'(!g_i));
        if (g_i) begin
            chk({tag, "_ierr"}, 64'(i_err), 64'(tmo));
            chk({tag, "_irdata"}, 64'(i_rdata), 64'(e_rdata));
        end else begin
            chk({tag, "_derr"}, 64'(d_err), 64'(tmo));
            chk({tag, "_drdata"}, 64'(d_rdata), 64'(e_rdata));
        end
    endtask

    task automatic finish_resp(input string tag);
        tick();
        chk_quiet(tag);
        chk({tag, "_errs"}, 64'({i_err, d_err}), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_addr", 64'(mem_addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        last_i = 1'b0;
    endtask

    initial begin
        bit g;
        int prev;

        do_reset();

        // Single fetch
        i_req = 1'b1; i_addr = 32'h100;
        run_txn("fetch", 2, 32'hDEADBEEF, g);
        i_req = 1'b0;
        finish_resp("fetch_idle");

        // Store to the high half
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12340000; d_be = 4'b1100;
        run_txn("sth", 3, 32'hFFFFFFFF, g);
        d_req = 1'b0;
        finish_resp("sth_idle");

        // Contention from reset with zero-wait memory
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'b0011;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            run_txn("cont", 1, 32'hA000 + 32'(k), g);
            chk("cont_order", 64'(i_ack), 64'((k % 2) == 0));
            if (k > 0) chk("cont_period", 64'(rise_cyc - prev), 64'd3);
            prev = rise_cyc;
            if (k == 5) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
        end
        chk_quiet("cont_end");

        // Watchdog expiry, then a late response must be dropped
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'b1111;
        run_txn("tmo", 1000, 32'h0, g);
        d_req = 1'b0;
        finish_resp("tmo_idle");
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        chk_quiet("late_ack");
        tick();
        chk_quiet("late_ack2");

        // Response coincides with the last watchdog cycle
        i_req = 1'b1; i_addr = 32'h104;
        run_txn("edge", int'(TO), 32'h55AA55AA, g);
        i_req = 1'b0;
        finish_resp("edge_idle");

        // Reset while a load is outstanding
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; d_be = 4'b1111;
        tick();
        tick();
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        repeat (2) @(posedge clk);
        i_req = 1'b1; i_addr = 32'h500;
        @(negedge clk);
        rst_n  = 1'b1;
        last_i = 1'b0;
        run_txn("post_rst", 2, 32'h0BADF00D, g);
        chk("post_rst_first_i", 64'(i_ack), 64'd1);
        i_req = 1'b0;
        finish_resp("post_rst_idle");
        run_txn("post_rst_d", 1, 32'h13579BDF, g);
        d_req = 1'b0;
        finish_resp("post_rst_d_idle");

        // Randomized traffic against the transaction model
        for (int n = 0; n < 60; n++) begin
            if (!i_req && $urandom_range(1, 0) == 1) begin
                i_req  = 1'b1;
                i_addr = $urandom();
            end
            if (!d_req && ($urandom_range(1, 0) == 1 || !i_req)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(1, 0));
                d_addr  = $urandom();
                d_wdata = $urandom();
                d_be    = BW'($urandom());
            end
            run_txn("rand", int'($urandom_range(TO + 2, 1)), $urandom(), g);
            if (g) i_req = 1'b0;
            else   d_req = 1'b0;
            tick();
            chk("rand_idle_acks", 64'({i_ack, d_ack}), 64'd0);
            chk("rand_idle_memreq", 64'(mem_req), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
